// File: rtl/fb_pingpong_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared constants and the scheduler state type for the camera/VGA
// double-buffered frame buffer.
//   C_IMG_PXLS     pixels per frame (80x60)
// C_NB_IMG_PXLS  address bits per bank
//   C_NB_BUF       pixel word width (RGB565)
//   C_NB_SWAP      width of the bank-swap counter
//   fb_state_t     IDLE / CAPTURE / READY
// -----------------------------------------------------------------------------
package fb_pkg;

   localparam int C_IMG_PXLS    = 4800;
   localparam int C_NB_IMG_PXLS = 13;
   localparam int C_NB_BUF      = 16;
   localparam int C_NB_SWAP     = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      READY   = 2'd2
   } fb_state_t;

endpackage

// File: rtl/fb_pingpong_ctrl_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Single-register edge detector. o_evt is high for one cycle when i_sig
// is at level c_act and was not at c_act on the previous clock.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   i_sig  in   level signal already in the clk domain
//   o_evt  out  one-cycle event: transition of i_sig into c_act
// -----------------------------------------------------------------------------
module sync_edge_det #(
   parameter logic c_act = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_sig,
   output logic o_evt
);

   logic r_sig;

   // Reset to the inactive level so a quiet input never fires after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sig <= ~c_act;
      end else begin
         r_sig <= i_sig;
      end
   end

   assign o_evt = (i_sig == c_act) && (r_sig != c_act);

endmodule

// File: rtl/fb_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// fb_pingpong_ctrl
// Double-buffer scheduler for the camera frame buffer. The camera writes
// the back bank while VGA reads the front bank; banks swap only on a VGA
// vsync that follows a complete camera frame, so a torn frame is never shown.
//
// Optional feature macro: FB_FREEZE_EN adds input 'freeze'; while it is 1
// a VGA vsync in READY does not swap, holding the displayed frame.
//
// Ports:
//   clk          in   clock (single domain)
//   rst          in   synchronous active-high reset
//   cam_vsync    in   camera frame marker, rising edge = frame start
//   cam_pxl_vld  in   one-cycle pixel strobe
//   cam_pxl      in   pixel data
//   vga_vsync    in   display vsync, active level c_synch_act
//   vga_addr     in   display pixel address within a bank
//   freeze       in   (FB_FREEZE_EN only) hold the displayed frame
//   fb_wr_en     out  RAM write enable (registered)
//   fb_wr_addr   out  {wr_bank, pixel index} (registered)
//   fb_wr_data   out  RAM write data (registered)
//   fb_rd_addr   out  {rd_bank, vga_addr}, combinational
//   frame_drop   out  one-cycle pulse: a camera frame was discarded
//   swap_cnt     out  number of bank swaps, wraps 255->0
//   o_dbg_state  out  current scheduler state
//
// Interface handshake: cam_pxl_vld is a valid-only strobe with no ready;
// a pixel is consumed in the cycle its strobe is high or it is lost. The
// RAM ports are write-only commands that the RAM always accepts.
// -----------------------------------------------------------------------------
module fb_pingpong_ctrl
   import fb_pkg::*;
#(
   parameter logic c_synch_act   = 1'b0,
   parameter int   c_img_pxls    = C_IMG_PXLS,
   parameter int   c_nb_img_pxls = C_NB_IMG_PXLS,
   parameter int   c_nb_buf      = C_NB_BUF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cam_vsync,
   input  logic                     cam_pxl_vld,
   input  logic [c_nb_buf-1:0]      cam_pxl,
   input  logic                     vga_vsync,
   input  logic [c_nb_img_pxls-1:0] vga_addr,
`ifdef FB_FREEZE_EN
   input  logic                     freeze,
`endif
   output logic                     fb_wr_en,
   output logic [c_nb_img_pxls:0]   fb_wr_addr,
   output logic [c_nb_buf-1:0]      fb_wr_data,
   output logic [c_nb_img_pxls:0]   fb_rd_addr,
   output logic                     frame_drop,
   output logic [C_NB_SWAP-1:0]     swap_cnt,
   output fb_state_t                o_dbg_state
);

   // One extra bit so the counter can hold c_img_pxls even when it is a
   // power of two.
   localparam int                 LP_NB_CNT = c_nb_img_pxls + 1;
   localparam logic [LP_NB_CNT-1:0] LP_IMG  = LP_NB_CNT'(c_img_pxls);

   logic                     w_cam_start;
   logic                     w_vga_start;
   logic                     w_swap_ok;
   logic [LP_NB_CNT-1:0]     w_cnt_nxt;

   fb_state_t                r_state;
   logic [LP_NB_CNT-1:0]     r_cnt;
   logic                     r_rd_bank;
   logic                     r_wr_bank;
   logic                     r_wr_en;
   logic [c_nb_img_pxls:0]   r_wr_addr;
   logic [c_nb_buf-1:0]      r_wr_data;
   logic                     r_drop;
   logic [C_NB_SWAP-1:0]     r_swap_cnt;

   sync_edge_det #(.c_act(1'b1)) u_cam_edge (
      .clk   (clk),
      .rst   (rst),
      .i_sig (cam_vsync),
      .o_evt (w_cam_start)
   );

   sync_edge_det #(.c_act(c_synch_act)) u_vga_edge (
      .clk   (clk),
      .rst   (rst),
      .i_sig (vga_vsync),
      .o_evt (w_vga_start)
   );

`ifdef FB_FREEZE_EN
   assign w_swap_ok = w_vga_start && !freeze;
`else
   assign w_swap_ok = w_vga_start;
`endif

   assign w_cnt_nxt = r_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_rd_bank  <= 1'b0;
         r_wr_bank  <= 1'b1;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= {1'b1, {c_nb_img_pxls{1'b0}}};
         r_wr_data  <= '0;
         r_drop     <= 1'b0;
         r_swap_cnt <= '0;
      end else begin
         // Pulse outputs default low; address/data hold their last value.
         r_wr_en <= 1'b0;
         r_drop  <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_cam_start) begin
                  r_cnt   <= '0;
                  r_state <= CAPTURE;
               end
            end

            CAPTURE: begin
               // A frame marker wins over a pixel strobe in the same cycle.
               if (w_cam_start) begin
                  if (r_cnt == LP_IMG) begin
                     r_state <= READY;
                  end else begin
                     r_drop <= 1'b1;
                     r_cnt  <= '0;
                  end
               end else if (cam_pxl_vld && (r_cnt < LP_IMG)) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= {r_wr_bank, r_cnt[c_nb_img_pxls-1:0]};
                  r_wr_data <= cam_pxl;
                  r_cnt     <= w_cnt_nxt;
                  // Last pixel: hand the bank over without waiting for vsync.
                  if (w_cnt_nxt == LP_IMG) begin
                     r_state <= READY;
                  end
               end
            end

            READY: begin
               if (w_swap_ok) begin
                  r_rd_bank  <= r_wr_bank;
                  r_wr_bank  <= r_rd_bank;
                  r_swap_cnt <= r_swap_cnt + 1'b1;
                  // A frame starting together with the swap is captured
                  // straight into the freshly freed bank.
                  if (w_cam_start) begin
                     r_cnt   <= '0;
                     r_state <= CAPTURE;
                  end else begin
                     r_state <= IDLE;
                  end
               end else if (w_cam_start) begin
                  r_drop <= 1'b1;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign fb_wr_en    = r_wr_en;
   assign fb_wr_addr  = r_wr_addr;
   assign fb_wr_data  = r_wr_data;
   assign fb_rd_addr  = {r_rd_bank, vga_addr};
   assign frame_drop  = r_drop;
   assign swap_cnt    = r_swap_cnt;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fb_pingpong_ctrl
// Self-checking bench for fb_pingpong_ctrl. Expected RAM writes are queued
// when pixels are driven and compared when fb_wr_en is seen.
// Build with FB_FREEZE_EN defined to also exercise the freeze input.
// -----------------------------------------------------------------------------
module tb_fb_pingpong_ctrl;
   import fb_pkg::*;

   localparam int NB  = C_NB_IMG_PXLS;
   localparam int IMG = C_IMG_PXLS;
   localparam int EW  = NB + 1 + C_NB_BUF;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                cam_vsync   = 1'b0;
   logic                cam_pxl_vld = 1'b0;
   logic [C_NB_BUF-1:0] cam_pxl     = '0;
   logic                vga_vsync   = 1'b1;
   logic [NB-1:0]       vga_addr    = 13'd5;
`ifdef FB_FREEZE_EN
   logic                freeze      = 1'b0;
`endif
   logic                fb_wr_en;
   logic [NB:0]         fb_wr_addr;
   logic [C_NB_BUF-1:0] fb_wr_data;
   logic [NB:0]         fb_rd_addr;
   logic                frame_drop;
   logic [7:0]          swap_cnt;
   fb_state_t           dbg_state;

   fb_pingpong_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cam_vsync   (cam_vsync),
      .cam_pxl_vld (cam_pxl_vld),
      .cam_pxl     (cam_pxl),
      .vga_vsync   (vga_vsync),
      .vga_addr    (vga_addr),
`ifdef FB_FREEZE_EN
      .freeze      (freeze),
`endif
      .fb_wr_en    (fb_wr_en),
      .fb_wr_addr  (fb_wr_addr),
      .fb_wr_data  (fb_wr_data),
      .fb_rd_addr  (fb_rd_addr),
      .frame_drop  (frame_drop),
      .swap_cnt    (swap_cnt),
      .o_dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int wr_seen  = 0;
   int drop_seen = 0;
   int m_cnt    = 0;   // bench model of pixel index
   logic m_bank = 1'b1; // bench model of write bank

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Outputs sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (fb_wr_en) begin
            wr_seen++;
            check("wr_not_rd_bank", 32'(fb_wr_addr[NB] != fb_rd_addr[NB]), 32'd1);
            if (exp_q.size() == 0) begin
               check("wr_unexpected", 32'(fb_wr_addr), 32'hFFFF_FFFF);
            end else begin
               check("wr_addr_data", 32'({fb_wr_addr, fb_wr_data}), 32'(exp_q.pop_front()));
            end
         end
         if (frame_drop) drop_seen++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cam_start();
      cam_vsync = 1'b1;
      tick(1);
      cam_vsync = 1'b0;
      tick(2);
   endtask

   task automatic vga_start();
      vga_vsync = 1'b0;
      tick(1);
      vga_vsync = 1'b1;
      tick(2);
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) begin
         cam_pxl     = C_NB_BUF'($urandom_range(0, 65535));
         cam_pxl_vld = 1'b1;
         if (m_cnt < IMG) begin
            exp_q.push_back({m_bank, NB'(m_cnt), cam_pxl});
            m_cnt++;
         end
         tick(1);
         cam_pxl_vld = 1'b0;
         // Occasional idle cycle between strobes.
         if ($urandom_range(0, 7) == 0) tick(1);
      end
      tick(2);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_wr_en"},   32'(fb_wr_en),   32'd0);
      check({tag, "_wr_addr"}, 32'(fb_wr_addr), 32'h2000);
      check({tag, "_wr_data"}, 32'(fb_wr_data), 32'd0);
      check({tag, "_drop"},    32'(frame_drop), 32'd0);
      check({tag, "_swap"},    32'(swap_cnt),   32'd0);
      check({tag, "_rd_addr"}, 32'(fb_rd_addr), 32'({1'b0, vga_addr}));
      check({tag, "_state"},   32'(dbg_state),  32'(IDLE));
   endtask

   // ---------------- test sequence ----------------
   int wr0, drop0;

   initial begin
      tick(3);
      @(negedge clk);
      check_reset_vals("rst");
      rst = 1'b0;
      tick(2);

      // 1: full frame into bank 1, then swap
      cam_start();
      m_cnt = 0; m_bank = 1'b1; wr0 = wr_seen;
      strobes(IMG);
      check("t1_writes", 32'(wr_seen - wr0), 32'(IMG));
      check("t1_q_empty", 32'(exp_q.size()), 32'd0);
      check("t1_ready", 32'(dbg_state), 32'(READY));
      check("t1_last_addr", 32'(fb_wr_addr), 32'h2000 + 32'(IMG - 1));
      vga_start();
      check("t1_swap_cnt", 32'(swap_cnt), 32'd1);
      check("t1_rd_addr", 32'(fb_rd_addr), 32'({1'b1, vga_addr}));
      check("t1_idle", 32'(dbg_state), 32'(IDLE));
      m_bank = 1'b0;

      // 2: short frame is dropped and capture restarts at index 0
      cam_start();
      m_cnt = 0; drop0 = drop_seen;
      strobes(100);
      cam_start();
      check("t2_drop", 32'(drop_seen - drop0), 32'd1);
      m_cnt = 0;
      strobes(IMG);
      check("t2_q_empty", 32'(exp_q.size()), 32'd0);
      check("t2_ready", 32'(dbg_state), 32'(READY));

      // 3: three frame starts while READY
      drop0 = drop_seen; wr0 = wr_seen;
      for (int k = 0; k < 3; k++) begin
         cam_start();
         strobes(5);
      end
      check("t3_drops", 32'(drop_seen - drop0), 32'd3);
      check("t3_no_writes", 32'(wr_seen - wr0), 32'd0);
      vga_start();
      check("t3_swap_cnt", 32'(swap_cnt), 32'd2);
      vga_start();
      check("t3_single_swap", 32'(swap_cnt), 32'd2);
      m_bank = 1'b1;

      // 4: overlong frame, no wrap
      cam_start();
      m_cnt = 0; wr0 = wr_seen;
      strobes(IMG + 5);
      check("t4_writes", 32'(wr_seen - wr0), 32'(IMG));
      check("t4_last_addr", 32'(fb_wr_addr), 32'h2000 + 32'(IMG - 1));
      check("t4_q_empty", 32'(exp_q.size()), 32'd0);

      // 5: cam_start and vga_start together in READY
      drop0 = drop_seen;
      cam_vsync = 1'b1;
      vga_vsync = 1'b0;
      tick(1);
      cam_vsync = 1'b0;
      vga_vsync = 1'b1;
      tick(2);
      check("t5_swap_cnt", 32'(swap_cnt), 32'd3);
      check("t5_capture", 32'(dbg_state), 32'(CAPTURE));
      check("t5_no_drop", 32'(drop_seen - drop0), 32'd0);
      check("t5_rd_bank", 32'(fb_rd_addr[NB]), 32'd1);
      m_bank = 1'b0; m_cnt = 0;

      // 6: reset mid-capture
      strobes(2000);
      check("t6_q_empty", 32'(exp_q.size()), 32'd0);
      rst = 1'b1;
      tick(1);
      @(negedge clk);
      check_reset_vals("t6");
      #1;
      rst = 1'b0;
      tick(2);
      cam_start();
      m_bank = 1'b1; m_cnt = 0;
      strobes(10);
      check("t6_q_empty2", 32'(exp_q.size()), 32'd0);
      check("t6_addr", 32'(fb_wr_addr), 32'h2009);

`ifdef FB_FREEZE_EN
      // 7: freeze holds the displayed frame
      strobes(IMG - 10);
      check("t7_ready", 32'(dbg_state), 32'(READY));
      freeze = 1'b1;
      for (int k = 0; k < 5; k++) vga_start();
      check("t7_frozen_swap", 32'(swap_cnt), 32'd0);
      check("t7_frozen_state", 32'(dbg_state), 32'(READY));
      freeze = 1'b0;
      tick(1);
      vga_start();
      check("t7_swap_after", 32'(swap_cnt), 32'd1);
`endif

      tick(3);
      check("end_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
